mul_reservation_station: RTL and testbench

//   NUM_ENTRIES-deep reservation station for RV32M multiply ops; sits between dispatch/rename and the multiplier FU.

---
 rtl/mul_reservation_station_pkg.sv | 65 ++++++
 rtl/mul_rs_select.sv | 27 ++
 rtl/mul_reservation_station.sv | 190 +++++++++++++++++++
 tb/tb_mul_reservation_station.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_reservation_station_pkg.sv
// Shared types for the RV32M multiply reservation station and the multiplier FU.
//   cdb_t              common data bus broadcast (valid, destination tag, result)
//   mul_rs_entry_t     one station slot: operand tags, ready bits, captured data, result tags
//   mul_issue_t        operands and tags driven to the multiplier while an op is in flight
//   mul_issue_state_t  issue handshake state, with the ISSUE_* constants
//   MUL_TYPE_*         operand signedness codes understood by the multiplier
package mul_reservation_station_pkg;

  localparam int PR_WIDTH  = 6;
  localparam int ROB_WIDTH = 4;

  localparam logic [1:0] MUL_TYPE_UU = 2'b11;
  localparam logic [1:0] MUL_TYPE_SS = 2'b00;
  localparam logic [1:0] MUL_TYPE_SU = 2'b10;

  typedef struct packed {
    logic                cdb_valid;
    logic [PR_WIDTH-1:0] phys_reg;
    logic [31:0]         data;
  } cdb_t;

  typedef struct packed {
    logic                 valid;
    logic [1:0]           mul_type;
    logic [PR_WIDTH-1:0]  ps1;
    logic                 ps1_rdy;
    logic [31:0]          ps1_data;
    logic [PR_WIDTH-1:0]  ps2;
    logic                 ps2_rdy;
    logic [31:0]          ps2_data;
    logic [ROB_WIDTH-1:0] rob;
    logic [PR_WIDTH-1:0]  pd;
    logic [4:0]           rd;
  } mul_rs_entry_t;

  typedef struct packed {
    logic [1:0]           mul_type;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [ROB_WIDTH-1:0] rob;
    logic [PR_WIDTH-1:0]  pd;
    logic [4:0]           rd;
  } mul_issue_t;

  typedef logic [1:0] mul_issue_state_t;
  localparam mul_issue_state_t ISSUE_IDLE    = 2'd0;
  localparam mul_issue_state_t ISSUE_BUSY    = 2'd1;
  localparam mul_issue_state_t ISSUE_RELEASE = 2'd2;

  // MUL keeps only the low word, so its signedness is irrelevant; it shares
  // the unsigned path with MULHU.
  function automatic logic [1:0] mul_type_of(input logic [2:0] funct3);
    case (funct3)
      3'b001:  return MUL_TYPE_SS;
      3'b010:  return MUL_TYPE_SU;
      default: return MUL_TYPE_UU;
    endcase
  endfunction

  // Tag 0 is x0: it never produces a result, so a broadcast on it wakes nothing.
  function automatic logic cdb_hit(input cdb_t c, input logic [PR_WIDTH-1:0] tag);
    return c.cdb_valid && (c.phys_reg == tag) && (tag != '0);
  endfunction

endpackage

// File: rtl/mul_rs_select.sv
// Lowest-index priority pick over a request vector.
//   req    in   N          request bits
//   found  out  1          any request set
//   idx    out  clog2(N)   index of the lowest set request (0 when none)
module mul_rs_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  // Scan from the top so the lowest set bit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mul_reservation_station.sv
// Reservation station for RV32M multiplies, between rename/dispatch and the multiplier FU.
// Holds ops until both sources are captured (at dispatch or by CDB snoop), picks the
// lowest-index ready op and runs the start/done handshake with the FU.
// Ports:
//   clk, rst (sync, active-high), branch (flush, same effect as rst on the station)
//   dispatch_*  op offered by dispatch; dispatch_ready = a free entry exists
//   cdb         result broadcast used for operand wakeup
//   mul_done    FU done; mul_start/mul_type/mul_a/mul_b/mul_rob/mul_phys_reg/mul_arch_reg to FU
// Build option MUL_RS_PERF_EN adds perf_issue_cnt (ops issued) and perf_full_cnt
// (cycles dispatch was stalled by a full station); both cleared by rst only.
//
// state   | meaning
// IDLE    | no op at the FU; issue the lowest ready entry if any
// BUSY    | mul_start high, operands held until mul_done
// RELEASE | mul_start low, operands held until the FU reports done again
module mul_reservation_station
  import mul_reservation_station_pkg::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branch,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  input  logic [2:0]           dispatch_funct3,
  input  logic [PR_WIDTH-1:0]  dispatch_ps1,
  input  logic [PR_WIDTH-1:0]  dispatch_ps2,
  input  logic                 dispatch_ps1_rdy,
  input  logic                 dispatch_ps2_rdy,
  input  logic [31:0]          dispatch_ps1_data,
  input  logic [31:0]          dispatch_ps2_data,
  input  logic [ROB_WIDTH-1:0] dispatch_rob,
  input  logic [PR_WIDTH-1:0]  dispatch_pd,
  input  logic [4:0]           dispatch_rd,
  input  cdb_t                 cdb,
  input  logic                 mul_done,
  output logic                 mul_start,
  output logic [1:0]           mul_type,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic [ROB_WIDTH-1:0] mul_rob,
  output logic [PR_WIDTH-1:0]  mul_phys_reg,
  output logic [4:0]           mul_arch_reg
`ifdef MUL_RS_PERF_EN
  ,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_full_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  mul_rs_entry_t    entries [NUM_ENTRIES];
  mul_rs_entry_t    dispatch_entry;
  mul_issue_t       issue_q;
  mul_issue_state_t state;

  logic [NUM_ENTRIES-1:0] free_req;
  logic [NUM_ENTRIES-1:0] ready_req;
  logic                   free_found;
  logic                   ready_found;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       ready_idx;
  logic                   dispatch_fire;
  logic                   issue_fire;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_req[i]  = !entries[i].valid;
      ready_req[i] = entries[i].valid && entries[i].ps1_rdy && entries[i].ps2_rdy;
    end
  end

  mul_rs_select #(.N(NUM_ENTRIES)) u_free_select (
    .req   (free_req),
    .found (free_found),
    .idx   (free_idx)
  );

  mul_rs_select #(.N(NUM_ENTRIES)) u_ready_select (
    .req   (ready_req),
    .found (ready_found),
    .idx   (ready_idx)
  );

  // Only registered occupancy counts: a slot vacated by this cycle's issue is
  // offered from the next cycle, which also keeps dispatch off the issuing entry.
  assign dispatch_ready = free_found;
  assign dispatch_fire  = dispatch_valid && free_found;
  assign issue_fire     = (state == ISSUE_IDLE) && ready_found;

  // A source broadcast in the dispatch cycle would otherwise be missed, since
  // the entry is not yet valid for snooping.
  always_comb begin
    dispatch_entry          = '0;
    dispatch_entry.valid    = 1'b1;
    dispatch_entry.mul_type = mul_type_of(dispatch_funct3);
    dispatch_entry.ps1      = dispatch_ps1;
    dispatch_entry.ps1_rdy  = dispatch_ps1_rdy;
    dispatch_entry.ps1_data = dispatch_ps1_data;
    dispatch_entry.ps2      = dispatch_ps2;
    dispatch_entry.ps2_rdy  = dispatch_ps2_rdy;
    dispatch_entry.ps2_data = dispatch_ps2_data;
    dispatch_entry.rob      = dispatch_rob;
    dispatch_entry.pd       = dispatch_pd;
    dispatch_entry.rd       = dispatch_rd;
    if (!dispatch_ps1_rdy && cdb_hit(cdb, dispatch_ps1)) begin
      dispatch_entry.ps1_rdy  = 1'b1;
      dispatch_entry.ps1_data = cdb.data;
    end
    if (!dispatch_ps2_rdy && cdb_hit(cdb, dispatch_ps2)) begin
      dispatch_entry.ps2_rdy  = 1'b1;
      dispatch_entry.ps2_data = cdb.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || branch) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= '0;
      end
      issue_q <= '0;
      state   <= ISSUE_IDLE;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (entries[i].valid) begin
          if (!entries[i].ps1_rdy && cdb_hit(cdb, entries[i].ps1)) begin
            entries[i].ps1_rdy  <= 1'b1;
            entries[i].ps1_data <= cdb.data;
          end
          if (!entries[i].ps2_rdy && cdb_hit(cdb, entries[i].ps2)) begin
            entries[i].ps2_rdy  <= 1'b1;
            entries[i].ps2_data <= cdb.data;
          end
        end
      end

      if (issue_fire) begin
        entries[ready_idx].valid <= 1'b0;
      end
      if (dispatch_fire) begin
        entries[free_idx] <= dispatch_entry;
      end

      case (state)
        ISSUE_IDLE: begin
          if (ready_found) begin
            issue_q.mul_type <= entries[ready_idx].mul_type;
            issue_q.a        <= entries[ready_idx].ps1_data;
            issue_q.b        <= entries[ready_idx].ps2_data;
            issue_q.rob      <= entries[ready_idx].rob;
            issue_q.pd       <= entries[ready_idx].pd;
            issue_q.rd       <= entries[ready_idx].rd;
            state            <= ISSUE_BUSY;
          end
        end
        ISSUE_BUSY: begin
          if (mul_done) state <= ISSUE_RELEASE;
        end
        ISSUE_RELEASE: begin
          if (mul_done) state <= ISSUE_IDLE;
        end
        default: state <= ISSUE_IDLE;
      endcase
    end
  end

  assign mul_start    = (state == ISSUE_BUSY);
  assign mul_type     = issue_q.mul_type;
  assign mul_a        = issue_q.a;
  assign mul_b        = issue_q.b;
  assign mul_rob      = issue_q.rob;
  assign mul_phys_reg = issue_q.pd;
  assign mul_arch_reg = issue_q.rd;

`ifdef MUL_RS_PERF_EN
  // A flush in the issue cycle cancels the transition, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (issue_fire && !branch) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (dispatch_valid && !dispatch_ready) perf_full_cnt <= perf_full_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_reservation_station.sv
module tb_mul_reservation_station;
  import mul_reservation_station_pkg::*;

  localparam int NE = 4;

  logic                 clk = 1'b0;
  logic                 rst, branch;
  logic                 dispatch_valid, dispatch_ready;
  logic [2:0]           dispatch_funct3;
  logic [PR_WIDTH-1:0]  dispatch_ps1, dispatch_ps2;
  logic                 dispatch_ps1_rdy, dispatch_ps2_rdy;
  logic [31:0]          dispatch_ps1_data, dispatch_ps2_data;
  logic [ROB_WIDTH-1:0] dispatch_rob;
  logic [PR_WIDTH-1:0]  dispatch_pd;
  logic [4:0]           dispatch_rd;
  cdb_t                 cdb;
  logic                 mul_done, mul_start;
  logic [1:0]           mul_type;
  logic [31:0]          mul_a, mul_b;
  logic [ROB_WIDTH-1:0] mul_rob;
  logic [PR_WIDTH-1:0]  mul_phys_reg;
  logic [4:0]           mul_arch_reg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_reservation_station #(.NUM_ENTRIES(NE)) dut (
    .clk(clk), .rst(rst), .branch(branch),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_funct3(dispatch_funct3),
    .dispatch_ps1(dispatch_ps1), .dispatch_ps2(dispatch_ps2),
    .dispatch_ps1_rdy(dispatch_ps1_rdy), .dispatch_ps2_rdy(dispatch_ps2_rdy),
    .dispatch_ps1_data(dispatch_ps1_data), .dispatch_ps2_data(dispatch_ps2_data),
    .dispatch_rob(dispatch_rob), .dispatch_pd(dispatch_pd), .dispatch_rd(dispatch_rd),
    .cdb(cdb), .mul_done(mul_done), .mul_start(mul_start), .mul_type(mul_type),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rob(mul_rob),
    .mul_phys_reg(mul_phys_reg), .mul_arch_reg(mul_arch_reg)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    branch = 0; dispatch_valid = 0; dispatch_funct3 = 0;
    dispatch_ps1 = 0; dispatch_ps2 = 0; dispatch_ps1_rdy = 0; dispatch_ps2_rdy = 0;
    dispatch_ps1_data = 0; dispatch_ps2_data = 0; dispatch_rob = 0; dispatch_pd = 0; dispatch_rd = 0;
    cdb = '0; mul_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic dispatch_op(input logic [2:0] f3,
                             input logic [PR_WIDTH-1:0] t1, input logic r1, input logic [31:0] d1,
                             input logic [PR_WIDTH-1:0] t2, input logic r2, input logic [31:0] d2,
                             input logic [ROB_WIDTH-1:0] rob, input logic [PR_WIDTH-1:0] pd,
                             input logic [4:0] rd);
    dispatch_valid = 1; dispatch_funct3 = f3;
    dispatch_ps1 = t1; dispatch_ps1_rdy = r1; dispatch_ps1_data = d1;
    dispatch_ps2 = t2; dispatch_ps2_rdy = r2; dispatch_ps2_data = d2;
    dispatch_rob = rob; dispatch_pd = pd; dispatch_rd = rd;
  endtask

  task automatic set_cdb(input logic v, input logic [PR_WIDTH-1:0] tag, input logic [31:0] d);
    cdb.cdb_valid = v; cdb.phys_reg = tag; cdb.data = d;
  endtask

  task automatic test_reset();
    do_reset();
    dispatch_op(3'b011, 6'd5, 1, 32'd7, 6'd6, 1, 32'd9, 4'd3, 6'd33, 5'd10);
    tick(); dispatch_valid = 0; tick(); tick();
    n_checks++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL reset_pre_start: got %0b want 1", mul_start); end
    rst = 1; tick(); rst = 0;
    n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b want 0", mul_start); end
    n_checks++; if (dispatch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", dispatch_ready); end
    n_checks++; if (mul_a !== 32'd0) begin n_fail++; $display("FAIL reset_a: got %h want 0", mul_a); end
    n_checks++; if (mul_b !== 32'd0) begin n_fail++; $display("FAIL reset_b: got %h want 0", mul_b); end
    n_checks++; if (mul_type !== 2'b00) begin n_fail++; $display("FAIL reset_type: got %b want 00", mul_type); end
    n_checks++; if ({mul_rob, mul_phys_reg, mul_arch_reg} !== '0) begin n_fail++; $display("FAIL reset_tags: got %h want 0", {mul_rob, mul_phys_reg, mul_arch_reg}); end
    tick(); tick();
    n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL reset_no_reissue: got %0b want 0", mul_start); end
  endtask

  task automatic test_basic_latency();
    do_reset();
    dispatch_op(3'b011, 6'd5, 1, 32'd7, 6'd6, 1, 32'd9, 4'd3, 6'd33, 5'd10);
    tick(); dispatch_valid = 0;
    n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL basic_n1_start: got %0b want 0", mul_start); end
    tick();
    n_checks++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL basic_n2_start: got %0b want 1", mul_start); end
    n_checks++; if (mul_a !== 32'd7 || mul_b !== 32'd9) begin n_fail++; $display("FAIL basic_operands: got a=%0d b=%0d want 7 9", mul_a, mul_b); end
    n_checks++; if (mul_type !== 2'b11) begin n_fail++; $display("FAIL basic_type: got %b want 11", mul_type); end
    n_checks++; if (mul_rob !== 4'd3 || mul_phys_reg !== 6'd33 || mul_arch_reg !== 5'd10) begin
      n_fail++; $display("FAIL basic_tags: got %0d %0d %0d want 3 33 10", mul_rob, mul_phys_reg, mul_arch_reg); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (mul_start !== 1'b1 || mul_a !== 32'd7) begin n_fail++; $display("FAIL basic_hold: got start=%0b a=%0d want 1 7", mul_start, mul_a); end
    end
    mul_done = 1; tick();
    n_checks++; if (mul_start !== 1'b0 || mul_b !== 32'd9) begin n_fail++; $display("FAIL basic_release: got start=%0b b=%0d want 0 9", mul_start, mul_b); end
    tick(); mul_done = 0;
    n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %0b want 0", mul_start); end
  endtask

  task automatic test_cdb_wakeup();
    do_reset();
    dispatch_op(3'b000, 6'd3, 1, 32'h11, 6'd12, 0, 32'h0, 4'd5, 6'd40, 5'd12);
    tick(); dispatch_valid = 0;
    set_cdb(1, 6'd13, 32'h55);
    tick(); set_cdb(0, 0, 0);
    n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL wake_wrong_tag: got %0b want 0", mul_start); end
    tick(); set_cdb(1, 6'd12, 32'hFFFFFFFE);
    n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL wake_before: got %0b want 0", mul_start); end
    tick(); set_cdb(0, 0, 0);
    n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL wake_no_bypass_issue: got %0b want 0", mul_start); end
    tick();
    n_checks++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL wake_start: got %0b want 1", mul_start); end
    n_checks++; if (mul_b !== 32'hFFFFFFFE || mul_a !== 32'h11) begin n_fail++; $display("FAIL wake_operands: got a=%h b=%h want 11 fffffffe", mul_a, mul_b); end
    mul_done = 1; tick(); tick(); mul_done = 0;
  endtask

  task automatic test_dispatch_bypass();
    do_reset();
    dispatch_op(3'b001, 6'd9, 0, 32'hDEAD, 6'd0, 1, 32'd0, 4'd6, 6'd41, 5'd13);
    set_cdb(1, 6'd9, 32'hABCD);
    tick(); dispatch_valid = 0; set_cdb(0, 0, 0);
    n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL bypass_n1: got %0b want 0", mul_start); end
    tick();
    n_checks++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL bypass_start: got %0b want 1", mul_start); end
    n_checks++; if (mul_a !== 32'hABCD || mul_b !== 32'd0) begin n_fail++; $display("FAIL bypass_operands: got a=%h b=%h want abcd 0", mul_a, mul_b); end
    n_checks++; if (mul_type !== 2'b00) begin n_fail++; $display("FAIL bypass_type: got %b want 00", mul_type); end
    mul_done = 1; tick(); tick(); mul_done = 0;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dispatch_op(3'b010, PR_WIDTH'(20 + i), 0, 32'd0, 6'd0, 1, 32'd0, ROB_WIDTH'(i), PR_WIDTH'(50 + i), 5'(i));
      tick();
    end
    dispatch_op(3'b000, 6'd30, 1, 32'd1, 6'd31, 1, 32'd2, 4'd9, 6'd60, 5'd20);
    n_checks++; if (dispatch_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", dispatch_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (dispatch_ready !== 1'b0 || mul_start !== 1'b0) begin
        n_fail++; $display("FAIL full_hold: got ready=%0b start=%0b want 0 0", dispatch_ready, mul_start); end
    end
    set_cdb(1, 6'd22, 32'h12345678);
    tick(); set_cdb(0, 0, 0);
    n_checks++; if (dispatch_ready !== 1'b0 || mul_start !== 1'b0) begin
      n_fail++; $display("FAIL full_wake_cycle: got ready=%0b start=%0b want 0 0", dispatch_ready, mul_start); end
    tick();
    n_checks++; if (mul_start !== 1'b1 || dispatch_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_issue: got start=%0b ready=%0b want 1 1", mul_start, dispatch_ready); end
    n_checks++; if (mul_a !== 32'h12345678 || mul_rob !== 4'd2 || mul_type !== 2'b10) begin
      n_fail++; $display("FAIL full_issue_op: got a=%h rob=%0d type=%b want 12345678 2 10", mul_a, mul_rob, mul_type); end
    dispatch_valid = 0;
    mul_done = 1; tick(); tick(); mul_done = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    dispatch_op(3'b000, 6'd1, 1, 32'd3, 6'd2, 1, 32'd4, 4'd1, 6'd11, 5'd1);
    tick();
    dispatch_op(3'b001, 6'd3, 1, 32'd5, 6'd4, 1, 32'd6, 4'd2, 6'd12, 5'd2);
    tick(); dispatch_valid = 0;
    n_checks++; if (mul_start !== 1'b1 || mul_a !== 32'd3) begin n_fail++; $display("FAIL b2b_first: got start=%0b a=%0d want 1 3", mul_start, mul_a); end
    for (int i = 0; i < 63; i++) begin
      tick();
      n_checks++; if (mul_start !== 1'b1 || mul_a !== 32'd3) begin n_fail++; $display("FAIL b2b_busy_hold: got start=%0b a=%0d want 1 3", mul_start, mul_a); end
    end
    mul_done = 1; tick(); mul_done = 0;
    n_checks++; if (mul_start !== 1'b0 || mul_a !== 32'd3) begin n_fail++; $display("FAIL b2b_release: got start=%0b a=%0d want 0 3", mul_start, mul_a); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (mul_start !== 1'b0 || mul_b !== 32'd4) begin n_fail++; $display("FAIL b2b_release_wait: got start=%0b b=%0d want 0 4", mul_start, mul_b); end
    end
    mul_done = 1; tick(); mul_done = 0;
    n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %0b want 0", mul_start); end
    tick();
    n_checks++; if (mul_start !== 1'b1 || mul_a !== 32'd5 || mul_type !== 2'b00) begin
      n_fail++; $display("FAIL b2b_second: got start=%0b a=%0d type=%b want 1 5 00", mul_start, mul_a, mul_type); end
    mul_done = 1; tick(); tick(); mul_done = 0;
    // Done while idle with an empty station must not start anything.
    mul_done = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL idle_done_ignored: got %0b want 0", mul_start); end
    end
    mul_done = 0;
  endtask

  task automatic test_flush();
    do_reset();
    dispatch_op(3'b011, 6'd1, 1, 32'd100, 6'd2, 1, 32'd200, 4'd7, 6'd17, 5'd7);
    tick();
    for (int i = 0; i < 3; i++) begin
      dispatch_op(3'b000, PR_WIDTH'(30 + i), 0, 32'd0, 6'd3, 1, 32'd1, ROB_WIDTH'(i), PR_WIDTH'(40 + i), 5'(i));
      tick();
    end
    dispatch_valid = 0;
    n_checks++; if (mul_start !== 1'b1 || mul_a !== 32'd100) begin n_fail++; $display("FAIL flush_pre_busy: got start=%0b a=%0d want 1 100", mul_start, mul_a); end
    branch = 1; tick(); branch = 0;
    n_checks++; if (mul_start !== 1'b0 || dispatch_ready !== 1'b1 || mul_a !== 32'd0) begin
      n_fail++; $display("FAIL flush_state: got start=%0b ready=%0b a=%0d want 0 1 0", mul_start, dispatch_ready, mul_a); end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_cdb(1, PR_WIDTH'(30 + i), 32'hCAFE0000 + 32'(i)); else set_cdb(0, 0, 0);
      tick();
      n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL flush_entries_gone: got %0b want 0", mul_start); end
    end
  endtask

  // Reference model: the station as a set of slots, plus the phase of the op held at the FU.
  task automatic test_random();
    logic                 m_v [NE];
    logic [1:0]           m_ty [NE];
    logic [PR_WIDTH-1:0]  m_t1 [NE], m_t2 [NE], m_pd [NE];
    logic                 m_r1 [NE], m_r2 [NE];
    logic [31:0]          m_d1 [NE], m_d2 [NE];
    logic [ROB_WIDTH-1:0] m_rob [NE];
    logic [4:0]           m_rd [NE];
    int                   fu_phase;
    logic [1:0]           e_ty;
    logic [31:0]          e_a, e_b;
    logic [ROB_WIDTH-1:0] e_rob;
    logic [PR_WIDTH-1:0]  e_pd;
    logic [4:0]           e_rd;
    logic                 exp_ready;
    int                   pick, slot;

    do_reset();
    for (int i = 0; i < NE; i++) m_v[i] = 0;
    fu_phase = 0; e_ty = 0; e_a = 0; e_b = 0; e_rob = 0; e_pd = 0; e_rd = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_ready = 0;
      for (int i = 0; i < NE; i++) if (!m_v[i]) exp_ready = 1;
      n_checks++; if (dispatch_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready cyc %0d: got %0b want %0b", cyc, dispatch_ready, exp_ready); end
      n_checks++; if (mul_start !== (fu_phase == 1)) begin n_fail++; $display("FAIL rand_start cyc %0d: got %0b want %0b", cyc, mul_start, fu_phase == 1); end
      n_checks++; if (mul_type !== e_ty) begin n_fail++; $display("FAIL rand_type cyc %0d: got %b want %b", cyc, mul_type, e_ty); end
      n_checks++; if (mul_a !== e_a) begin n_fail++; $display("FAIL rand_a cyc %0d: got %h want %h", cyc, mul_a, e_a); end
      n_checks++; if (mul_b !== e_b) begin n_fail++; $display("FAIL rand_b cyc %0d: got %h want %h", cyc, mul_b, e_b); end
      n_checks++; if ({mul_rob, mul_phys_reg, mul_arch_reg} !== {e_rob, e_pd, e_rd}) begin
        n_fail++; $display("FAIL rand_tags cyc %0d: got %h want %h", cyc, {mul_rob, mul_phys_reg, mul_arch_reg}, {e_rob, e_pd, e_rd}); end

      dispatch_valid    = ($urandom_range(0, 2) != 0);
      dispatch_funct3   = 3'($urandom_range(0, 3));
      dispatch_ps1      = PR_WIDTH'($urandom_range(0, 7));
      dispatch_ps2      = PR_WIDTH'($urandom_range(0, 7));
      dispatch_ps1_rdy  = (dispatch_ps1 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      dispatch_ps2_rdy  = (dispatch_ps2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      dispatch_ps1_data = (dispatch_ps1 == 0) ? 32'd0 : $urandom;
      dispatch_ps2_data = (dispatch_ps2 == 0) ? 32'd0 : $urandom;
      dispatch_rob      = ROB_WIDTH'($urandom);
      dispatch_pd       = PR_WIDTH'($urandom);
      dispatch_rd       = 5'($urandom);
      set_cdb(1'($urandom_range(0, 1)), PR_WIDTH'($urandom_range(1, 7)), $urandom);
      mul_done          = ($urandom_range(0, 3) == 0);
      branch            = ($urandom_range(0, 59) == 0);

      if (branch) begin
        for (int i = 0; i < NE; i++) m_v[i] = 0;
        fu_phase = 0; e_ty = 0; e_a = 0; e_b = 0; e_rob = 0; e_pd = 0; e_rd = 0;
      end else begin
        pick = -1;
        if (fu_phase == 0)
          for (int i = NE - 1; i >= 0; i--) if (m_v[i] && m_r1[i] && m_r2[i]) pick = i;
        slot = -1;
        if (dispatch_valid)
          for (int i = NE - 1; i >= 0; i--) if (!m_v[i]) slot = i;
        if (pick >= 0) begin
          e_ty = m_ty[pick]; e_a = m_d1[pick]; e_b = m_d2[pick];
          e_rob = m_rob[pick]; e_pd = m_pd[pick]; e_rd = m_rd[pick];
        end
        for (int i = 0; i < NE; i++) begin
          if (m_v[i] && !m_r1[i] && cdb.cdb_valid && cdb.phys_reg == m_t1[i]) begin m_r1[i] = 1; m_d1[i] = cdb.data; end
          if (m_v[i] && !m_r2[i] && cdb.cdb_valid && cdb.phys_reg == m_t2[i]) begin m_r2[i] = 1; m_d2[i] = cdb.data; end
        end
        if (fu_phase == 1 && mul_done) fu_phase = 2;
        else if (fu_phase == 2 && mul_done) fu_phase = 0;
        else if (fu_phase == 0 && pick >= 0) begin fu_phase = 1; m_v[pick] = 0; end
        if (slot >= 0) begin
          m_v[slot] = 1;
          m_ty[slot] = (dispatch_funct3 == 3'd1) ? 2'b00 : (dispatch_funct3 == 3'd2) ? 2'b10 : 2'b11;
          m_t1[slot] = dispatch_ps1; m_t2[slot] = dispatch_ps2;
          m_r1[slot] = dispatch_ps1_rdy; m_d1[slot] = dispatch_ps1_data;
          m_r2[slot] = dispatch_ps2_rdy; m_d2[slot] = dispatch_ps2_data;
          if (!m_r1[slot] && cdb.cdb_valid && cdb.phys_reg == m_t1[slot]) begin m_r1[slot] = 1; m_d1[slot] = cdb.data; end
          if (!m_r2[slot] && cdb.cdb_valid && cdb.phys_reg == m_t2[slot]) begin m_r2[slot] = 1; m_d2[slot] = cdb.data; end
          m_rob[slot] = dispatch_rob; m_pd[slot] = dispatch_pd; m_rd[slot] = dispatch_rd;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1;
    clear_inputs();
    #1;
    test_reset();
    test_basic_latency();
    test_cdb_wakeup();
    test_dispatch_bypass();
    test_full();
    test_back_to_back();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
